// File: rtl/alu_issue_queue.sv
// Tagged command FIFO and issue stage for the 2-stage pipelined ALU; results return as tagged responses.
// Optional opcode legality check enabled by defining ALU_ISSUE_OPCHK_EN.
module alu_issue_queue #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_opcode,
    input  logic [WIDTH-1:0]           cmd_a,
    input  logic [WIDTH-1:0]           cmd_b,
    input  logic [4:0]                 cmd_shift,
    input  logic [TAG_W-1:0]           cmd_tag,
    input  logic                       hold,
    input  logic                       flush,
    output logic [3:0]                 alu_opcode,
    output logic [WIDTH-1:0]           alu_input1,
    output logic [WIDTH-1:0]           alu_input2,
    output logic [4:0]                 alu_shiftValue,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       alu_carry,
    input  logic                       alu_zero,
    input  logic                       alu_sign,
    output logic                       rsp_valid,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_carry,
    output logic                       rsp_zero,
    output logic                       rsp_sign,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_illegal
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [4:0]       shift;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic              issue;

    // Index 0 is loaded alongside the alu_* registers; ALU_LAT further stages track the ALU pipeline.
    logic [ALU_LAT:0]  dl_valid;
    logic [TAG_W-1:0]  dl_tag [ALU_LAT+1];

    assign head       = mem[rd_ptr];
    assign cmd_ready  = (count < CW'(DEPTH));
    assign fifo_count = count;
    assign push       = cmd_valid && cmd_ready && !flush;
    assign pop        = (count != '0) && !hold && !flush;

`ifdef ALU_ISSUE_OPCHK_EN
    logic illegal;
    logic err_q;

    assign illegal     = (head.opcode > 4'd9);
    assign issue       = pop && !illegal;
    assign err_illegal = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (pop && illegal) begin
            err_q <= 1'b1;
        end
    end
`else
    assign issue       = pop;
    assign err_illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, shift: cmd_shift, tag: cmd_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
        end else if (issue) begin
            alu_opcode     <= head.opcode;
            alu_input1     <= head.a;
            alu_input2     <= head.b;
            alu_shiftValue <= head.shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
            for (int unsigned i = 0; i <= ALU_LAT; i++) begin
                dl_tag[i] <= '0;
            end
        end else begin
            dl_valid[0] <= issue;
            if (issue) begin
                dl_tag[0] <= head.tag;
            end
            for (int unsigned i = 1; i <= ALU_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1] && !flush;
                dl_tag[i]   <= dl_tag[i-1];
            end
        end
    end

    assign rsp_valid  = dl_valid[ALU_LAT];
    assign rsp_tag    = dl_tag[ALU_LAT];
    assign rsp_result = alu_result;
    assign rsp_carry  = alu_carry;
    assign rsp_zero   = alu_zero;
    assign rsp_sign   = alu_sign;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a queue-based reference model and a 2-stage ALU stand-in.
module tb_alu_issue_queue;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned ALU_LAT = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [3:0]         cmd_opcode = '0;
    logic [WIDTH-1:0]   cmd_a = '0;
    logic [WIDTH-1:0]   cmd_b = '0;
    logic [4:0]         cmd_shift = '0;
    logic [TAG_W-1:0]   cmd_tag = '0;
    logic               hold = 1'b0;
    logic               flush = 1'b0;
    logic [3:0]         alu_opcode;
    logic [WIDTH-1:0]   alu_input1;
    logic [WIDTH-1:0]   alu_input2;
    logic [4:0]         alu_shiftValue;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic               alu_zero;
    logic               alu_sign;
    logic               rsp_valid;
    logic [TAG_W-1:0]   rsp_tag;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_carry;
    logic               rsp_zero;
    logic               rsp_sign;
    logic [$clog2(DEPTH):0] fifo_count;
    logic               err_illegal;

    alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
        .hold(hold), .flush(flush),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
        .fifo_count(fifo_count), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // {carry, result}; opcodes above 9 give 0 like the real ALU default
    function automatic logic [WIDTH:0] alu_fn(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b, input logic [4:0] sh);
        case (op)
            4'd0: alu_fn = {1'b0, a} + {1'b0, b};
            4'd1: alu_fn = {1'b0, a} - {1'b0, b};
            4'd2: alu_fn = {1'b0, a & b};
            4'd3: alu_fn = {1'b0, a | b};
            4'd4: alu_fn = {1'b0, a ^ b};
            4'd5: alu_fn = {1'b0, ~(a | b)};
            4'd6: alu_fn = {1'b0, {(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd7: alu_fn = {1'b0, a << sh};
            4'd8: alu_fn = {1'b0, a >> sh};
            4'd9: alu_fn = {1'b0, WIDTH'($signed(a) >>> sh)};
            default: alu_fn = '0;
        endcase
    endfunction

    // ALU stand-in: result appears ALU_LAT (=2) edges after the alu_* ports change
    logic [WIDTH:0] alu_s1;
    logic [WIDTH:0] alu_s2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_s1 <= '0;
            alu_s2 <= '0;
        end else begin
            alu_s1 <= alu_fn(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
            alu_s2 <= alu_s1;
        end
    end
    assign alu_result = alu_s2[WIDTH-1:0];
    assign alu_carry  = alu_s2[WIDTH];
    assign alu_zero   = (alu_s2[WIDTH-1:0] == '0);
    assign alu_sign   = alu_s2[WIDTH-1];

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [4:0]       sh;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef struct packed {
        int               due;
        logic [TAG_W-1:0] tag;
        logic [WIDTH:0]   r;
    } exp_t;

    cmd_t   mq[$];
    exp_t   eq[$];
    int     cyc = 0;
    cmd_t   m_alu = '0;
    logic   m_err = 1'b0;
    int     total = 0;
    int     bad = 0;
    int     rsp_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending commands, list of responses due at a given edge number
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            eq.delete();
            m_alu = '0;
            m_err = 1'b0;
        end else begin
            logic do_push;
            cyc++;
            do_push = cmd_valid && (mq.size() < DEPTH) && !flush;
            if (flush) begin
                mq.delete();
                while (eq.size() > 0 && eq[eq.size()-1].due >= cyc) void'(eq.pop_back());
            end else begin
                if (mq.size() > 0 && !hold) begin
                    cmd_t c;
                    c = mq.pop_front();
`ifdef ALU_ISSUE_OPCHK_EN
                    if (c.op > 4'd9) begin
                        m_err = 1'b1;
                    end else begin
                        m_alu = c;
                        eq.push_back('{due: cyc + ALU_LAT, tag: c.tag, r: alu_fn(c.op, c.a, c.b, c.sh)});
                    end
`else
                    m_alu = c;
                    eq.push_back('{due: cyc + ALU_LAT, tag: c.tag, r: alu_fn(c.op, c.a, c.b, c.sh)});
`endif
                end
                if (do_push) begin
                    mq.push_back('{op: cmd_opcode, a: cmd_a, b: cmd_b, sh: cmd_shift, tag: cmd_tag});
                end
            end
        end
    end

    always @(negedge clk) begin
        logic ev;
        exp_t e;
        chk("fifo_count", fifo_count, mq.size());
        chk("cmd_ready", cmd_ready, (mq.size() < DEPTH));
        chk("alu_ports", {alu_opcode, alu_input1, alu_input2, alu_shiftValue},
            {m_alu.op, m_alu.a, m_alu.b, m_alu.sh});
        chk("err_illegal", err_illegal, m_err);
        ev = (eq.size() > 0) && (eq[0].due == cyc);
        chk("rsp_valid", rsp_valid, ev);
        if (rsp_valid === 1'b1) rsp_seen++;
        if (ev) begin
            e = eq.pop_front();
            chk("rsp_tag", rsp_tag, e.tag);
            chk("rsp_result", rsp_result, e.r[WIDTH-1:0]);
            chk("rsp_carry", rsp_carry, e.r[WIDTH]);
            chk("rsp_zero", rsp_zero, (e.r[WIDTH-1:0] == '0));
            chk("rsp_sign", rsp_sign, e.r[WIDTH-1]);
        end
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [4:0] sh, input logic [TAG_W-1:0] tg,
                         input logic h, input logic f);
        cmd_valid = v; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh; cmd_tag = tg;
        hold = h; flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, '0, '0, 5'd0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int base;
        @(posedge clk); #1;
        chk("reset_count", fifo_count, 0);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_alu", {alu_opcode, alu_input1, alu_input2, alu_shiftValue}, 0);
        chk("reset_rsp", {rsp_valid, rsp_tag}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // single ADD: alu_* after E1, response after E3
        drive(1'b1, 4'd0, 32'd5, 32'd7, 5'd0, 4'd3, 1'b0, 1'b0);
        idle(1);
        chk("e1_alu_in1", alu_input1, 5);
        chk("e1_alu_in2", alu_input2, 7);
        idle(2);
        chk("e3_rsp_valid", rsp_valid, 1);
        chk("e3_rsp_tag", rsp_tag, 3);
        chk("e3_rsp_result", rsp_result, 12);
        chk("e3_rsp_carry", rsp_carry, 0);
        idle(1);
        chk("e4_rsp_valid", rsp_valid, 0);

        // fill under hold, overflow offer, then drain
        for (int i = 0; i < 4; i++)
            drive(1'b1, 4'(i + 1), 32'(100 + i), 32'(3 * i + 1), 5'(i), 4'(i), 1'b1, 1'b0);
        chk("full_ready", cmd_ready, 0);
        chk("full_count", fifo_count, 4);
        drive(1'b1, 4'd0, 32'd9, 32'd9, 5'd0, 4'd9, 1'b1, 1'b0);
        chk("full_count_after_offer", fifo_count, 4);
        base = rsp_seen;
        idle(8);
        chk("drain_rsp_count", rsp_seen - base, 4);

        // steady stream with pointer wrap
        base = rsp_seen;
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 4'(i % 10), 32'hFFFF_FFF0 + 32'(i), 32'(i * 7 + 3), 5'(i + 1), 4'(i), 1'b0, 1'b0);
            chk("stream_ready", cmd_ready, 1);
            chk("stream_count_le1", (fifo_count <= 1), 1);
        end
        idle(5);
        chk("stream_rsp_count", rsp_seen - base, 14);

        // flush with 2 queued + 1 in flight
        drive(1'b1, 4'd0, 32'd1, 32'd2, 5'd0, 4'd8, 1'b1, 1'b0);
        drive(1'b1, 4'd1, 32'd9, 32'd2, 5'd0, 4'd9, 1'b1, 1'b0);
        drive(1'b1, 4'd2, 32'd6, 32'd3, 5'd0, 4'd10, 1'b0, 1'b0);
        base = rsp_seen;
        drive(1'b1, 4'd0, 32'd4, 32'd4, 5'd0, 4'd7, 1'b0, 1'b1);
        chk("flush_count", fifo_count, 0);
        idle(5);
        chk("flush_no_rsp", rsp_seen - base, 0);
        drive(1'b1, 4'd0, 32'd20, 32'd22, 5'd0, 4'd11, 1'b0, 1'b0);
        idle(5);
        chk("post_flush_rsp", rsp_seen - base, 1);

        // async reset with 2 queued + 2 in flight
        drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd0, 4'd12, 1'b1, 1'b0);
        drive(1'b1, 4'd3, 32'd2, 32'd1, 5'd0, 4'd13, 1'b1, 1'b0);
        drive(1'b1, 4'd4, 32'd3, 32'd1, 5'd0, 4'd14, 1'b0, 1'b0);
        drive(1'b1, 4'd7, 32'd4, 32'd1, 5'd2, 4'd15, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_alu", {alu_opcode, alu_input1, alu_input2, alu_shiftValue}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        base = rsp_seen;
        idle(6);
        chk("rst_no_stale", rsp_seen - base, 0);

        // illegal opcode followed by ADD 1+1
        base = rsp_seen;
        drive(1'b1, 4'd12, 32'd3, 32'd3, 5'd0, 4'd5, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd0, 4'd6, 1'b0, 1'b0);
        idle(6);
`ifdef ALU_ISSUE_OPCHK_EN
        chk("illegal_err", err_illegal, 1);
        chk("illegal_rsp_count", rsp_seen - base, 1);
`else
        chk("illegal_err", err_illegal, 0);
        chk("illegal_rsp_count", rsp_seen - base, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
